// File: rtl/rd_addr_gen_pkg.sv
// Shared types and default geometry for the sample-buffer read address sequencer.
package rd_addr_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DEPTH      = 100;
  localparam int DEF_ADDR_WIDTH = 7;

endpackage

// File: rtl/rd_addr_cnt.sv
// Loadable up-counter holding the current read address.
module rd_addr_cnt #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_val,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] cnt
);

  // clear outranks load, load outranks increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rd_addr_gen.sv
// Read-side address sequencer: streams addresses 0..len-1 under valid/ready, then pulses done.
module rd_addr_gen
  import rd_addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  input  logic                  clear_i,
  output logic                  addr_valid_o,
  input  logic                  addr_ready_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_W   = ADDR_WIDTH'(1);

  function automatic logic [ADDR_WIDTH-1:0] clamp_len(input logic [ADDR_WIDTH-1:0] len);
    return (len > DEPTH_W) ? DEPTH_W : len;
  endfunction

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    cnt_clr, cnt_load, cnt_inc;
  logic                    at_last;

  rd_addr_cnt #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .load    (cnt_load),
    .load_val('0),
    .inc     (cnt_inc),
    .cnt     (addr)
  );

  // len_q is never zero while in RUN, so len_q-1 cannot underflow there
  assign at_last = (addr == (len_q - ONE_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            len_d    = clamp_len(len_i);
            cnt_load = 1'b1;
            state_d  = (len_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // the final address is held rather than advanced, so it never walks past DEPTH-1
          if (addr_ready_i) begin
            if (at_last) begin
              state_d = DONE;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign rd_addr_o    = addr;
  assign addr_valid_o = (state_q == RUN);
  assign last_o       = addr_valid_o & at_last;
  assign busy_o       = (state_q == RUN) | (state_q == DONE);
  assign done_o       = (state_q == DONE);

endmodule

// File: doc/rd_addr_gen.md
# rd_addr_gen

Read-side address sequencer for the 100-entry sample buffer. The write side fills the buffer from address 0 upward and reports a fill count. This block is the matching reader: on a start command it streams read addresses 0 … len-1 to the buffer port under a valid/ready handshake, flags the last address, and pulses done when the final address is accepted.

## Interface
- ADDR_WIDTH, default 7: address width; 2^7 = 128 covers DEPTH.
- DEPTH, default 100: number of buffer entries; the highest legal address is DEPTH-1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_i  input  1  begin a read burst; sampled only in IDLE.
- len_i  input  ADDR_WIDTH  number of entries to read; sampled with start_i.
- clear_i  input  1  synchronous abort; returns the block to IDLE.
- addr_valid_o  output  1  rd_addr_o is valid.
- addr_ready_i  input  1  the buffer accepts rd_addr_o this cycle.
- rd_addr_o  output  ADDR_WIDTH  current read address.
- last_o  output  1  rd_addr_o is the final address of the burst; qualified by addr_valid_o.
- busy_o  output  1  high in RUN and DONE.
- done_o  output  1  one-cycle pulse after the last handshake.

## Operation
- States:
  - IDLE → RUN on start_i with len_i ≠ 0.
  - IDLE → DONE on start_i with len_i = 0.
  - RUN → DONE when the last address handshakes.
  - DONE → IDLE unconditionally, after one cycle.
- Length handling:
  - On start, len_reg = min(len_i, DEPTH).
  - len_i values from DEPTH+1 to 127 clamp to DEPTH.
- Address handling:
  - On start, the address resets to 0.
  - In RUN, addr_valid_o = 1.
  - A handshake is addr_valid_o & addr_ready_i. Each handshake increments the address by 1.
  - rd_addr_o holds its value while addr_ready_i = 0.
- Last flag:
  - last_o = addr_valid_o & (rd_addr_o == len_reg-1).
  - A handshake with last_o = 1 moves RUN → DONE. The address does not increment; it holds len_reg-1.
  - The address never wraps past DEPTH-1.
- Ignored inputs: start_i in RUN or DONE is ignored, and len_i is not resampled.
- clear_i:
  - Has priority over every other input in any state.
  - Next state is IDLE and the address goes to 0.
  - No done_o pulse.
  - A handshake occurring in the same cycle as clear_i is still consumed by the buffer, but it is not counted.
- Outputs in IDLE: addr_valid_o = 0, last_o = 0, busy_o = 0.
- Reset: state IDLE, rd_addr_o = 0, len_reg = 0, and all outputs 0.
- Reset asserted mid-burst forces those values immediately (asynchronously). No done_o pulse follows reset deassertion.

## Timing
- start_i sampled high at edge t → addr_valid_o high and rd_addr_o = 0 from t (registered; visible in cycle t+1).
- With addr_ready_i held high, one address per cycle: rd_addr_o = k in cycle t+1+k.
- Last handshake in cycle c → done_o = 1 in cycle c+1, busy_o = 1 in cycle c+1, IDLE in cycle c+2.
- Earliest accepted next start is in cycle c+2 (a back-to-back burst gap of 1 cycle).
- Zero-length start at t → done_o in cycle t+1. addr_valid_o never rises.
- All outputs are registered or decoded from registers only. There is no combinational path from addr_ready_i to any output.

## Structure
- Package rd_addr_gen_pkg holds:
  - The state enum: IDLE, RUN, DONE.
  - Default DEPTH = 100 and ADDR_WIDTH = 7.
- Sub-module rd_addr_cnt: a loadable up-counter with these controls:
  - synchronous clear
  - increment enable
  - asynchronous active-high reset
- The FSM, length clamp and last/done logic live in the top module.

## Test plan
- **Reset:** assert rst mid-burst at rd_addr_o = 5 → all outputs 0 immediately. After release, no done_o; idle until start.
- **Full-rate burst:** len_i = 4, addr_ready_i = 1 → rd_addr_o 0, 1, 2, 3 on consecutive cycles, last_o with 3, done_o once on the next cycle.
- **Backpressure:** len_i = 3, addr_ready_i toggling 1, 0, 0, 1, 1 → addresses 0, 1, 1, 1, 2. Address held while ready is low; done_o after address 2 is accepted.
- **Clamp:** len_i = 120 → exactly 100 handshakes, last_o at rd_addr_o = 99, no address ≥ 100.
- **Zero length:** len_i = 0 → done_o one cycle after start, addr_valid_o stays 0.
- **Abort and ignored start:** start_i pulsed in RUN at address 2 has no effect. clear_i at address 2 → IDLE next cycle, no done_o. A new start with len_i = 2 then yields addresses 0, 1.
